// File: rtl/voter_session.sv
// Voting session controller: collects one ballot per voter, counts the
// ballots, and announces win/tie/lose as a one-hot code with a one-cycle pulse.
module voter_session #(
  parameter int N       = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N-1:0]           vote_valid,
  input  logic [N-1:0]           vote_yes,
  input  logic                   close,
  output logic                   busy,
  output logic                   result_valid,
  output logic [3:1]             O,
  output logic [$clog2(N+1)-1:0] yes_cnt,
  output logic [$clog2(N+1)-1:0] voted_cnt
);

  localparam int         CW       = $clog2(N + 1);
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [CW:0] N_W     = (CW + 1)'(N);

  // IDLE: wait for start | COLLECT: take ballots | TALLY: count | RESULT: announce
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    TALLY   = 2'd2,
    RESULT  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  voted_q, voted_d;
  logic [N-1:0]  yes_q, yes_d;
  logic [N-1:0]  fresh;
  logic [7:0]    timer_q, timer_d;
  logic [CW-1:0] yes_pop, voted_pop;
  logic [CW-1:0] yes_cnt_q, yes_cnt_d;
  logic [CW-1:0] voted_cnt_q, voted_cnt_d;
  logic [3:1]    dec_q, dec_d;
  logic [3:1]    decision;
  logic [CW:0]   twice_yes;
  logic          collect_done;

  always_comb begin
    yes_pop   = '0;
    voted_pop = '0;
    for (int i = 0; i < N; i++) begin
      yes_pop   = yes_pop + CW'(yes_q[i]);
      voted_pop = voted_pop + CW'(voted_q[i]);
    end
  end

  // Abstentions count as not-yes, so the comparison is against N, not voted_pop.
  always_comb begin
    twice_yes = {yes_pop, 1'b0};
    decision  = 3'b100;
    if (twice_yes > N_W) begin
      decision = 3'b001;
    end else if (twice_yes == N_W) begin
      decision = 3'b010;
    end
  end

  always_comb begin
    state_d      = state_q;
    voted_d      = voted_q;
    yes_d        = yes_q;
    timer_d      = timer_q;
    yes_cnt_d    = yes_cnt_q;
    voted_cnt_d  = voted_cnt_q;
    dec_d        = dec_q;
    fresh        = vote_valid & ~voted_q;
    collect_done = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = COLLECT;
          voted_d = '0;
          yes_d   = '0;
          timer_d = '0;
        end
      end
      COLLECT: begin
        voted_d      = voted_q | fresh;
        yes_d        = yes_q | (vote_yes & fresh);
        timer_d      = timer_q + 8'd1;
        collect_done = close || (&voted_d) || (timer_q == TMO_LAST);
        if (collect_done) begin
          state_d = TALLY;
        end
      end
      TALLY: begin
        yes_cnt_d   = yes_pop;
        voted_cnt_d = voted_pop;
        dec_d       = decision;
        state_d     = RESULT;
      end
      RESULT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      voted_q     <= '0;
      yes_q       <= '0;
      timer_q     <= '0;
      yes_cnt_q   <= '0;
      voted_cnt_q <= '0;
      dec_q       <= 3'b100;
    end else begin
      state_q     <= state_d;
      voted_q     <= voted_d;
      yes_q       <= yes_d;
      timer_q     <= timer_d;
      yes_cnt_q   <= yes_cnt_d;
      voted_cnt_q <= voted_cnt_d;
      dec_q       <= dec_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign result_valid = (state_q == RESULT);
  assign O            = dec_q;
  assign yes_cnt      = yes_cnt_q;
  assign voted_cnt    = voted_cnt_q;

endmodule

// File: tb/tb_voter_session.sv
// Bench for voter_session: two instances (N=4/TIMEOUT=5 and N=5/TIMEOUT=7)
// checked against a per-session ballot model.
module tb_voter_session;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic       start_a, close_a, start_b, close_b;
   logic [4:0] vv, vy;
   logic       busy_a, rv_a, busy_b, rv_b;
   logic [3:1] o_a, o_b;
   logic [2:0] yc_a, vc_a, yc_b, vc_b;

   int errors = 0;
   int checks = 0;

   logic [4:0] sv[16];
   logic [4:0] sy[16];
   logic       sc[16];

   voter_session #(.N(4), .TIMEOUT(5)) dut_a (
      .clk(clk), .rst_n(rst_n), .start(start_a),
      .vote_valid(vv[3:0]), .vote_yes(vy[3:0]), .close(close_a),
      .busy(busy_a), .result_valid(rv_a), .O(o_a),
      .yes_cnt(yc_a), .voted_cnt(vc_a)
   );

   voter_session #(.N(5), .TIMEOUT(7)) dut_b (
      .clk(clk), .rst_n(rst_n), .start(start_b),
      .vote_valid(vv), .vote_yes(vy), .close(close_b),
      .busy(busy_b), .result_valid(rv_b), .O(o_b),
      .yes_cnt(yc_b), .voted_cnt(vc_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ctl(input int sel, input logic st, input logic cl);
      start_a = (sel == 0) ? st : 1'b0;
      close_a = (sel == 0) ? cl : 1'b0;
      start_b = (sel == 1) ? st : 1'b0;
      close_b = (sel == 1) ? cl : 1'b0;
   endtask

   task automatic obs(input int sel, output logic b, output logic r,
                      output logic [3:1] o, output logic [2:0] y,
                      output logic [2:0] v);
      b = (sel == 1) ? busy_b : busy_a;
      r = (sel == 1) ? rv_b   : rv_a;
      o = (sel == 1) ? o_b    : o_a;
      y = (sel == 1) ? yc_b   : yc_a;
      v = (sel == 1) ? vc_b   : vc_a;
   endtask

   task automatic clear_stim();
      for (int c = 0; c < 16; c++) begin
         sv[c] = '0;
         sy[c] = '0;
         sc[c] = 1'b0;
      end
   endtask

   // Plays sv/sy/sc into one instance and checks every cycle of the session.
   task automatic run_session(input int sel, input string name);
      int n, tmo, k, ycnt, vcnt, allv;
      int voted[5];
      int yv[5];
      logic [3:1] exp_o, o;
      logic b, r, eb, er;
      logic [2:0] y, v;

      n   = (sel == 1) ? 5 : 4;
      tmo = (sel == 1) ? 7 : 5;
      for (int i = 0; i < 5; i++) begin
         voted[i] = 0;
         yv[i]    = 0;
      end
      k = tmo - 1;
      for (int c = 0; c < tmo; c++) begin
         for (int i = 0; i < n; i++) begin
            if (sv[c][i] && voted[i] == 0) begin
               voted[i] = 1;
               yv[i]    = int'(sy[c][i]);
            end
         end
         allv = 1;
         for (int i = 0; i < n; i++) if (voted[i] == 0) allv = 0;
         if (sc[c] || allv == 1 || c == tmo - 1) begin
            k = c;
            break;
         end
      end
      ycnt = 0;
      vcnt = 0;
      for (int i = 0; i < n; i++) begin
         ycnt += yv[i];
         vcnt += voted[i];
      end
      if (2 * ycnt > n)       exp_o = 3'b001;
      else if (2 * ycnt == n) exp_o = 3'b010;
      else                    exp_o = 3'b100;

      // Ballots presented alongside start land in IDLE and must be ignored.
      vv = 5'($urandom);
      vy = 5'($urandom);
      set_ctl(sel, 1'b1, 1'($urandom));
      tick();
      obs(sel, b, r, o, y, v);
      checks++;
      if (b !== 1'b1) begin
         errors++;
         $display("FAIL %s busy_after_start got=%b exp=1", name, b);
      end

      for (int i = 0; i <= k + 3; i++) begin
         if (i <= k) begin
            vv = sv[i];
            vy = sy[i];
            set_ctl(sel, 1'b0, sc[i]);
         end else begin
            vv = 5'($urandom);
            vy = 5'($urandom);
            set_ctl(sel, (i <= k + 2) ? 1'($urandom) : 1'b0, 1'($urandom));
         end
         tick();
         obs(sel, b, r, o, y, v);
         eb = (i <= k + 1);
         er = (i == k + 1);
         checks++;
         if (b !== eb) begin
            errors++;
            $display("FAIL %s busy cyc=%0d got=%b exp=%b", name, i, b, eb);
         end
         checks++;
         if (r !== er) begin
            errors++;
            $display("FAIL %s result_valid cyc=%0d got=%b exp=%b", name, i, r, er);
         end
         if (i == k + 1 || i == k + 3) begin
            checks++;
            if (o !== exp_o) begin
               errors++;
               $display("FAIL %s O cyc=%0d got=%b exp=%b", name, i, o, exp_o);
            end
            checks++;
            if (y !== 3'(ycnt)) begin
               errors++;
               $display("FAIL %s yes_cnt cyc=%0d got=%0d exp=%0d", name, i, y, ycnt);
            end
            checks++;
            if (v !== 3'(vcnt)) begin
               errors++;
               $display("FAIL %s voted_cnt cyc=%0d got=%0d exp=%0d", name, i, v, vcnt);
            end
         end
      end
      set_ctl(sel, 1'b0, 1'b0);
      vv = '0;
      vy = '0;
   endtask

   task automatic test_reset();
      logic b, r;
      logic [3:1] o;
      logic [2:0] y, v;
      rst_n = 1'b0;
      for (int c = 0; c < 3; c++) begin
         start_a = 1'b1;
         start_b = 1'b1;
         close_a = 1'($urandom);
         close_b = 1'($urandom);
         vv = 5'($urandom);
         vy = 5'($urandom);
         tick();
      end
      for (int s = 0; s < 2; s++) begin
         obs(s, b, r, o, y, v);
         checks++;
         if (b !== 1'b0) begin
            errors++;
            $display("FAIL reset busy dut=%0d got=%b exp=0", s, b);
         end
         checks++;
         if (r !== 1'b0) begin
            errors++;
            $display("FAIL reset result_valid dut=%0d got=%b exp=0", s, r);
         end
         checks++;
         if (o !== 3'b100) begin
            errors++;
            $display("FAIL reset O dut=%0d got=%b exp=100", s, o);
         end
         checks++;
         if (y !== 3'd0 || v !== 3'd0) begin
            errors++;
            $display("FAIL reset counts dut=%0d got=%0d/%0d exp=0/0", s, y, v);
         end
      end
      set_ctl(0, 1'b0, 1'b0);
      vv = '0;
      vy = '0;
      rst_n = 1'b1;
      tick();
   endtask

   task automatic test_all_vote_one_cycle();
      clear_stim();
      sv[0] = 5'b01111;
      sy[0] = 5'b00111;
      run_session(0, "all_voted");
      checks++;
      if (o_a !== 3'b001 || yc_a !== 3'd3 || vc_a !== 3'd4) begin
         errors++;
         $display("FAIL all_voted final got=%b/%0d/%0d exp=001/3/4", o_a, yc_a, vc_a);
      end
   endtask

   task automatic test_tie_separate();
      clear_stim();
      sv[0] = 5'b00001; sy[0] = 5'b00001;
      sv[1] = 5'b00010; sy[1] = 5'b00010;
      sv[2] = 5'b00100; sy[2] = 5'b00000;
      sv[3] = 5'b01000; sy[3] = 5'b00000;
      run_session(0, "tie");
      checks++;
      if (o_a !== 3'b010 || yc_a !== 3'd2) begin
         errors++;
         $display("FAIL tie final got=%b/%0d exp=010/2", o_a, yc_a);
      end
   endtask

   task automatic test_repeat_ignored();
      clear_stim();
      sv[0] = 5'b00001; sy[0] = 5'b00001;
      sv[1] = 5'b00001; sy[1] = 5'b00000;
      sc[2] = 1'b1;
      run_session(0, "repeat");
      checks++;
      if (o_a !== 3'b100 || yc_a !== 3'd1 || vc_a !== 3'd1) begin
         errors++;
         $display("FAIL repeat final got=%b/%0d/%0d exp=100/1/1", o_a, yc_a, vc_a);
      end
   endtask

   task automatic test_timeout();
      clear_stim();
      run_session(0, "timeout");
      checks++;
      if (o_a !== 3'b100 || vc_a !== 3'd0) begin
         errors++;
         $display("FAIL timeout final got=%b/%0d exp=100/0", o_a, vc_a);
      end
   endtask

   task automatic test_odd_n();
      clear_stim();
      sv[0] = 5'b11111;
      sy[0] = 5'b10101;
      run_session(1, "odd_n");
      checks++;
      if (o_b !== 3'b001 || yc_b !== 3'd3 || vc_b !== 3'd5) begin
         errors++;
         $display("FAIL odd_n final got=%b/%0d/%0d exp=001/3/5", o_b, yc_b, vc_b);
      end
   endtask

   task automatic test_sweep();
      for (int p = 0; p < 16; p++) begin
         clear_stim();
         sv[0] = 5'b01111;
         sy[0] = 5'(p);
         run_session(0, "sweep");
      end
   endtask

   task automatic test_random();
      int sel;
      for (int s = 0; s < 40; s++) begin
         sel = int'($urandom_range(0, 1));
         for (int c = 0; c < 16; c++) begin
            sv[c] = 5'($urandom) & 5'($urandom);
            sy[c] = 5'($urandom);
            sc[c] = ($urandom_range(0, 7) == 0);
         end
         run_session(sel, "random");
      end
   endtask

   task automatic test_reset_mid_collect();
      // Make the held outputs nonzero first so the reset has something to clear.
      clear_stim();
      sv[0] = 5'b01111;
      sy[0] = 5'b01111;
      run_session(0, "pre_abort");

      set_ctl(0, 1'b1, 1'b0);
      tick();
      set_ctl(0, 1'b0, 1'b0);
      vv = 5'b00011;
      vy = 5'b00011;
      tick();
      rst_n = 1'b0;
      set_ctl(0, 1'b1, 1'b1);
      vv = 5'b01100;
      vy = 5'b01100;
      tick();
      checks++;
      if (busy_a !== 1'b0 || rv_a !== 1'b0) begin
         errors++;
         $display("FAIL abort busy/rv got=%b/%b exp=0/0", busy_a, rv_a);
      end
      checks++;
      if (o_a !== 3'b100 || yc_a !== 3'd0 || vc_a !== 3'd0) begin
         errors++;
         $display("FAIL abort outputs got=%b/%0d/%0d exp=100/0/0", o_a, yc_a, vc_a);
      end
      rst_n = 1'b1;
      set_ctl(0, 1'b0, 1'b0);
      vv = '0;
      vy = '0;
      for (int c = 0; c < 4; c++) begin
         tick();
         checks++;
         if (rv_a !== 1'b0 || busy_a !== 1'b0) begin
            errors++;
            $display("FAIL abort no_pulse cyc=%0d got=%b/%b exp=0/0", c, rv_a, busy_a);
         end
      end

      clear_stim();
      sv[0] = 5'b00100;
      sy[0] = 5'b00100;
      sc[1] = 1'b1;
      run_session(0, "after_abort");
      checks++;
      if (yc_a !== 3'd1 || vc_a !== 3'd1) begin
         errors++;
         $display("FAIL after_abort counts got=%0d/%0d exp=1/1", yc_a, vc_a);
      end
   endtask

   initial begin
      rst_n   = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      close_a = 1'b0;
      close_b = 1'b0;
      vv      = '0;
      vy      = '0;
      test_reset();
      test_all_vote_one_cycle();
      test_tie_separate();
      test_repeat_ignored();
      test_timeout();
      test_odd_n();
      test_sweep();
      test_random();
      test_reset_mid_collect();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/voter_session.md
VOTER_SESSION -- requirements
Module: voter_session

Interface
REQ-001 The module SHALL have parameter N, default 4, giving the number of voters (legal range 2..16).
REQ-002 The module SHALL have parameter TIMEOUT, default 16, giving the maximum COLLECT duration in cycles (legal range 1..255).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The module SHALL have port start, input, 1 bit: open a voting session.
REQ-006 The module SHALL have port vote_valid, input, N bits: bit i high means voter i casts a ballot this cycle.
REQ-007 The module SHALL have port vote_yes, input, N bits: ballot value of voter i (1 = yes), sampled only with vote_valid[i].
REQ-008 The module SHALL have port close, input, 1 bit: force the session to end.
REQ-009 The module SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-010 The module SHALL have port result_valid, output, 1 bit: one-cycle pulse announcing a decision.
REQ-011 The module SHALL have port O, output, 3 bits [3:1]: one-hot decision; O[3] = lose, O[2] = tie, O[1] = win.
REQ-012 The module SHALL have port yes_cnt, output, $clog2(N+1) bits: yes ballots counted in the last closed session.
REQ-013 The module SHALL have port voted_cnt, output, $clog2(N+1) bits: total ballots counted in the last closed session.

Function
REQ-014 The FSM SHALL have four states, IDLE, COLLECT, TALLY and RESULT, with IDLE as the reset state.
REQ-015 start in IDLE SHALL move to COLLECT on the next cycle and clear the per-voter voted/yes registers and the timer.
REQ-016 start SHALL be ignored in COLLECT, TALLY and RESULT.
REQ-017 In COLLECT, voter i's vote_yes[i] SHALL be latched when vote_valid[i]=1 and voter i has not yet voted; the voter is then marked voted.
REQ-018 In COLLECT, repeat ballots from a voter already marked voted SHALL be ignored, so the first ballot stands.
REQ-019 Ballots presented outside COLLECT SHALL be ignored.
REQ-020 The timer SHALL increment every COLLECT cycle.
REQ-021 COLLECT SHALL move to TALLY after any cycle in which at least one of these holds: close=1; all N voters are marked voted, including ballots latched in that cycle; or the timer reaches TIMEOUT-1.
REQ-022 Ballots presented in the closing cycle SHALL be counted.
REQ-023 TALLY SHALL last exactly one cycle and register yes_cnt as the popcount of the yes registers and voted_cnt as the popcount of the voted registers.
REQ-024 The decision SHALL be computed from yes count Y over all N voters, with abstentions counting as not-yes: 2Y > N gives O=3'b001 (win); 2Y == N gives O=3'b010 (tie); 2Y < N gives O=3'b100 (lose).
REQ-025 For N=4 the decision SHALL be: Y=0..1 lose, Y=2 tie, Y=3..4 win.
REQ-026 In odd N the tie outcome SHALL be unreachable.
REQ-027 RESULT SHALL last exactly one cycle with result_valid=1, then return to IDLE.
REQ-028 O, yes_cnt and voted_cnt SHALL update in the RESULT cycle and hold until the next session's RESULT.
REQ-029 Latency SHALL be: closing COLLECT cycle k, TALLY at k+1, result_valid at k+2.
REQ-030 start asserted in the RESULT cycle SHALL be ignored; a new session needs start in IDLE.
REQ-031 O SHALL always be one-hot after the first RESULT; no X or all-zero value after reset.

Reset
REQ-032 While rst_n=0 at a clock edge, the next state SHALL be IDLE and all per-voter registers and the timer SHALL be 0.
REQ-033 While rst_n=0 at a clock edge, busy=0, result_valid=0, O=3'b100, yes_cnt=0 and voted_cnt=0.
REQ-034 Reset asserted in any state, including mid-COLLECT, SHALL abandon the session with no result_valid pulse.
REQ-035 rst_n SHALL take priority over start, close and votes in the same cycle.

Verification
REQ-036 N=4; start, then ballots yes,yes,yes,no in one cycle -> all-voted closes; result_valid 2 cycles later; O=001, yes_cnt=3, voted_cnt=4.
REQ-037 N=4; ballots yes,yes,no,no over separate cycles -> O=010 (tie), yes_cnt=2.
REQ-038 N=4; voter0 yes then voter0 no, then close -> second ballot ignored; yes_cnt=1, voted_cnt=1, O=100.
REQ-039 N=4, TIMEOUT=5; start, no ballots -> TALLY after the 5th COLLECT cycle; O=100, voted_cnt=0; busy high throughout.
REQ-040 N=5; 3 yes, 2 no -> O=001. Sweep all 2^N ballot patterns for N=4 and check O against REQ-024.
REQ-041 Reset asserted mid-COLLECT with 2 yes ballots -> no pulse; outputs back to reset values; a new session counts from 0.
